// File: rtl/key_input_ctrl_if.sv
// Processor data-bus view of a memory-mapped peripheral (MAR/WrMem/DrMem path).
// Ports: addr, rd_en, wr_en, wdata driven by the core; rdata, sel returned by the device.
// The core gates rdata onto thebus only while sel is high.
interface key_input_ctrl_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             rd_en;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             sel;

  // Core side: issues accesses, samples read data.
  modport master (
    output addr, rd_en, wr_en, wdata,
    input  rdata, sel
  );

  // Device side: decodes accesses, returns read data.
  modport slave (
    input  addr, rd_en, wr_en, wdata,
    output rdata, sel
  );
endinterface

// File: rtl/key_input_ctrl.sv
// Pushbutton input device: syncs/debounces 4 active-low keys, exposes KDATA/KCTRL, raises irq.
// Latency: stable key state follows a held pin change 2+DEBOUNCE_CYC edges later; rdata/sel combinational.
// Backpressure: none; every bus access completes in the cycle it is presented.
// Ports: clk, reset (async, active-high), key_n[3:0] raw keys, bus (slave modport: addr, rd_en,
//        wr_en, wdata in; rdata, sel out), irq = Ready & IE (registered).
module key_input_ctrl #(
  parameter int                DBITS        = 32,
  parameter logic [DBITS-1:0]  ADDRKDATA    = 32'hFFFFF080,
  parameter logic [DBITS-1:0]  ADDRKCTRL    = 32'hFFFFF084,
  parameter int                DEBOUNCE_CYC = 50000,
  parameter int                CNTBITS      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         key_n,
  key_input_ctrl_if.slave    bus,
  output logic               irq
);

  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYC - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]              sync1_q, sync1_d;
  logic [3:0]              sync2_q, sync2_d;
  logic [3:0]              stable_q, stable_d;
  logic [3:0][CNTBITS-1:0] cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    oe_q, oe_d;
  logic                    ie_q, ie_d;
  logic                    irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic hit_kdata;
  logic hit_kctrl;
  logic kdata_rd;     // read of KDATA that is allowed to acknowledge Ready
  logic kctrl_wr;
  logic [3:0] bit_chg;
  logic change;
  logic [DBITS-1:0] rdata_dat;
  logic sel_vld;

  assign hit_kdata = (bus.addr == ADDRKDATA);
  assign hit_kctrl = (bus.addr == ADDRKCTRL);

  // A read overlapping a write is treated as no read: the write wins and
  // nothing is acknowledged.
  assign kdata_rd  = bus.rd_en & ~bus.wr_en & hit_kdata;
  assign kctrl_wr  = bus.wr_en & hit_kctrl;

  // Only IE (bit 4) and the OE clear (bit 2) are writable.
  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[DBITS-1:5], bus.wdata[3], bus.wdata[1:0]};

  // ---------------------------------------------------------------------------
  // Synchronizer + per-bit debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d  = ~key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    bit_chg  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        // Input agrees with accepted state (or bounced back): restart.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Differed for DEBOUNCE_CYC consecutive edges: accept it.
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        bit_chg[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign change = |bit_chg;

  // ---------------------------------------------------------------------------
  // Status / control
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d = ready_q;
    oe_d    = oe_q;
    ie_d    = ie_q;

    // Set beats the KDATA acknowledge.
    if (change) begin
      ready_d = 1'b1;
    end else if (kdata_rd) begin
      ready_d = 1'b0;
    end

    // Overrun: a new change lands while the previous one is unread.
    // Set beats the software clear on the same edge.
    if (change && ready_q && !kdata_rd) begin
      oe_d = 1'b1;
    end else if (kctrl_wr && !bus.wdata[2]) begin
      oe_d = 1'b0;
    end

    if (kctrl_wr) begin
      ie_d = bus.wdata[4];
    end

    // Built from next-state so irq rises on the same edge as Ready.
    irq_d = ready_d & ie_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      oe_q     <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      oe_q     <= oe_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: combinational, forced quiet while reset is held
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_dat = '0;
    sel_vld   = 1'b0;
    if (!reset) begin
      if (hit_kdata) begin
        rdata_dat = {{(DBITS-4){1'b0}}, stable_q};
      end else if (hit_kctrl) begin
        rdata_dat = {{(DBITS-5){1'b0}}, ie_q, 1'b0, oe_q, 1'b0, ready_q};
      end
      sel_vld = bus.rd_en & (hit_kdata | hit_kctrl);
    end
  end

  assign bus.rdata = rdata_dat;
  assign bus.sel   = sel_vld;
  assign irq       = irq_q;

endmodule
